// File: rtl/vc_rr_scheduler.sv
// vc_rr_scheduler: round-robin scheduler that shares one downstream link among
// four first-word-fall-through virtual-channel FIFOs. Each grant pops up to
// BURST_LEN words from one VC, then priority rotates to the next VC.
module vc_rr_scheduler #(
  parameter int DATA_WIDTH = 10,
  parameter int BURST_LEN  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enb,
  input  logic [3:0]              empty,
  input  logic [4*DATA_WIDTH-1:0] data_in,
  input  logic                    almost_full,
  output logic [3:0]              pop,
  output logic                    push,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic [1:0]              vc_out,
  output logic                    busy
);

  typedef enum logic {
    ST_ARB   = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  localparam logic [3:0] LAST_CNT = 4'(BURST_LEN - 1);

  state_e                  state_q, state_d;
  logic [1:0]              ptr_q, ptr_d;
  logic [1:0]              gnt_q, gnt_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    push_q, push_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [1:0]              vc_q, vc_d;
  logic                    ok_s;
  logic [3:0]              pop_s;
  logic [DATA_WIDTH-1:0]   head_s [4];

  // First requesting VC found when scanning start, start+1, ... (mod 4).
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] start);
    logic [1:0] idx;
    logic [1:0] res;
    logic       found;
    res   = start;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = start + 2'(k);
      if (!found && req[idx]) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  for (genvar i = 0; i < 4; i++) begin : g_head
    assign head_s[i] = data_in[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Next-state logic: arbitration in ARB, burst counting and exit in GRANT.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    ok_s    = 1'b0;
    case (state_q)
      ST_ARB: begin
        if (enb && (empty != 4'b1111)) begin
          gnt_d   = rr_pick(~empty, ptr_q);
          cnt_d   = 4'd0;
          state_d = ST_GRANT;
        end else begin
          state_d = ST_ARB;
        end
      end
      ST_GRANT: begin
        ok_s = enb & ~empty[gnt_q] & ~almost_full;
        if (ok_s) begin
          cnt_d = cnt_q + 4'd1;
        end else begin
          cnt_d = cnt_q;
        end
        // Backpressure alone only stalls; an emptied VC or a full burst ends the grant.
        if ((ok_s && (cnt_q == LAST_CNT)) || (empty[gnt_q] && enb)) begin
          state_d = ST_ARB;
          ptr_d   = gnt_q + 2'd1;
        end else begin
          state_d = ST_GRANT;
        end
      end
      default: begin
        state_d = ST_ARB;
      end
    endcase
  end

  // One-hot read strobe to the granted VC; forced low while reset is asserted.
  always_comb begin
    pop_s = 4'b0000;
    if (ok_s && rst) begin
      pop_s[gnt_q] = 1'b1;
    end else begin
      pop_s = 4'b0000;
    end
  end

  // Output stage: the popped word is forwarded one cycle later; hold otherwise.
  always_comb begin
    push_d = ok_s;
    if (ok_s) begin
      data_d = head_s[gnt_q];
      vc_d   = gnt_q;
    end else begin
      data_d = data_q;
      vc_d   = vc_q;
    end
  end

  // State and output registers; enb=0 freezes everything because ok_s is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_ARB;
      ptr_q   <= 2'd0;
      gnt_q   <= 2'd0;
      cnt_q   <= 4'd0;
      push_q  <= 1'b0;
      data_q  <= '0;
      vc_q    <= 2'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      push_q  <= push_d;
      data_q  <= data_d;
      vc_q    <= vc_d;
    end
  end

  assign pop      = pop_s;
  assign push     = push_q;
  assign data_out = data_q;
  assign vc_out   = vc_q;
  assign busy     = (state_q == ST_GRANT);

endmodule

// File: tb/tb_vc_rr_scheduler.sv
// tb_vc_rr_scheduler: directed scenarios plus randomized traffic, checked
// cycle by cycle against a transaction-level model of the VC FIFOs and scheduler.
module tb_vc_rr_scheduler;

  localparam int DW = 10;
  localparam int BL = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          enb;
  logic [3:0]    empty;
  logic [4*DW-1:0] data_in;
  logic          almost_full;
  logic [3:0]    pop;
  logic          push;
  logic [DW-1:0] data_out;
  logic [1:0]    vc_out;
  logic          busy;

  always #5 clk = ~clk;

  vc_rr_scheduler #(.DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
    .clk(clk), .rst(rst), .enb(enb), .empty(empty), .data_in(data_in),
    .almost_full(almost_full), .pop(pop), .push(push), .data_out(data_out),
    .vc_out(vc_out), .busy(busy)
  );

  // Behavioural model: FIFO contents as queues, scheduler as a few integers.
  logic [DW-1:0] fifo_q [4][$];
  bit            m_serving;
  int            m_vc, m_count, m_next;
  logic          exp_push;
  logic [DW-1:0] exp_data;
  logic [1:0]    exp_vc;
  int            log_vc[$];
  logic [DW-1:0] log_data[$];
  int            vectors = 0;
  int            miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int vc, input int n, input int base);
    for (int k = 0; k < n; k++) fifo_q[vc].push_back(DW'(base + k));
  endtask

  function automatic bit all_empty();
    return (fifo_q[0].size() == 0) && (fifo_q[1].size() == 0) &&
           (fifo_q[2].size() == 0) && (fifo_q[3].size() == 0);
  endfunction

  // One clock: drive FIFO view, check pop, clock, update model, check outputs.
  task automatic cycle();
    logic [3:0] exp_pop;
    bit do_pop, leave, start;
    int pick;
    for (int i = 0; i < 4; i++) begin
      empty[i] = (fifo_q[i].size() == 0);
      data_in[i*DW +: DW] = (fifo_q[i].size() != 0) ? fifo_q[i][0] : DW'($urandom);
    end
    #1;
    exp_pop = 4'b0000; do_pop = 0; leave = 0; start = 0; pick = 0;
    if (rst) begin
      if (!m_serving) begin
        if (enb && !all_empty()) begin
          start = 1;
          for (int k = 3; k >= 0; k--)
            if (fifo_q[(m_next + k) % 4].size() != 0) pick = (m_next + k) % 4;
        end
      end else begin
        do_pop = enb && (fifo_q[m_vc].size() != 0) && !almost_full;
        leave  = (do_pop && (m_count == BL - 1)) || (enb && (fifo_q[m_vc].size() == 0));
        if (do_pop) exp_pop[m_vc] = 1'b1;
      end
    end
    check("pop", 32'(pop), 32'(exp_pop));
    @(posedge clk);
    if (!rst) begin
      m_serving = 0; m_next = 0; m_count = 0;
      exp_push = 1'b0; exp_data = '0; exp_vc = 2'd0;
    end else begin
      if (start) begin m_vc = pick; m_count = 0; m_serving = 1; end
      exp_push = do_pop;
      if (do_pop) begin
        exp_data = fifo_q[m_vc].pop_front();
        exp_vc   = 2'(m_vc);
        m_count++;
      end
      if (leave) begin m_serving = 0; m_next = (m_vc + 1) % 4; end
    end
    #1;
    check("push", 32'(push), 32'(exp_push));
    check("data_out", 32'(data_out), 32'(exp_data));
    check("vc_out", 32'(vc_out), 32'(exp_vc));
    check("busy", 32'(busy), 32'(m_serving));
    if (push === 1'b1) begin
      log_vc.push_back(int'(vc_out));
      log_data.push_back(data_out);
    end
    @(negedge clk);
  endtask

  task automatic run_idle(input string tag);
    int n;
    n = 0;
    while ((!all_empty() || m_serving) && n < 300) begin
      cycle();
      n++;
    end
    cycle();
    vectors++;
    if (n >= 300) begin
      miscompares++;
      $error("FAIL %s_timeout observed=%0d cycles expected=<300", tag, n);
    end
  endtask

  task automatic clear_log();
    log_vc.delete();
    log_data.delete();
  endtask

  initial begin
    rst = 1'b0; enb = 1'b0; almost_full = 1'b0; empty = 4'hF; data_in = '0;
    m_serving = 0; m_vc = 0; m_count = 0; m_next = 0;
    exp_push = 1'b0; exp_data = '0; exp_vc = 2'd0;
    @(negedge clk);
    cycle(); cycle();
    rst = 1'b1; enb = 1'b1;
    cycle();

    // Single VC with 6 words: burst of 4, gap, then the last 2.
    clear_log();
    load(2, 6, 10'h0A1);
    run_idle("t2");
    check("t2_count", 32'(log_vc.size()), 32'd6);
    for (int i = 0; i < log_vc.size() && i < 6; i++) begin
      check("t2_vc", 32'(log_vc[i]), 32'd2);
      check("t2_data", 32'(log_data[i]), 32'(10'h0A1 + i));
    end

    // Pointer sits at 3: VC0 must be served before VC2.
    clear_log();
    load(0, 1, 10'h050);
    load(2, 1, 10'h052);
    run_idle("t5");
    check("t5_count", 32'(log_vc.size()), 32'd2);
    if (log_vc.size() >= 2) begin
      check("t5_first", 32'(log_vc[0]), 32'd0);
      check("t5_second", 32'(log_vc[1]), 32'd2);
    end

    // Reset pulse, then one word per VC twice: order 0,1,2,3 both rounds.
    rst = 1'b0; cycle(); rst = 1'b1;
    clear_log();
    for (int v = 0; v < 4; v++) load(v, 1, 10'h100 + 16 * v);
    run_idle("t3a");
    for (int v = 0; v < 4; v++) load(v, 1, 10'h200 + 16 * v);
    run_idle("t3b");
    check("t3_count", 32'(log_vc.size()), 32'd8);
    for (int i = 0; i < log_vc.size() && i < 8; i++)
      check("t3_order", 32'(log_vc[i]), 32'(i % 4));

    // Backpressure for 3 cycles after the second word of a VC1 burst.
    clear_log();
    load(1, 4, 10'h311);
    cycle(); cycle(); cycle();
    almost_full = 1'b1;
    cycle(); cycle(); cycle();
    almost_full = 1'b0;
    run_idle("t4");
    check("t4_count", 32'(log_vc.size()), 32'd4);
    for (int i = 0; i < log_vc.size() && i < 4; i++)
      check("t4_vc", 32'(log_vc[i]), 32'd1);

    // Enable dropped for 2 cycles mid-burst on VC3.
    clear_log();
    load(3, 4, 10'h3C0);
    cycle(); cycle(); cycle();
    enb = 1'b0;
    cycle(); cycle();
    enb = 1'b1;
    run_idle("t6");
    check("t6_count", 32'(log_vc.size()), 32'd4);
    for (int i = 0; i < log_vc.size() && i < 4; i++)
      check("t6_data", 32'(log_data[i]), 32'(10'h3C0 + i));

    // Reset in the middle of a VC1 burst (two words out); VC0 then wins.
    load(1, 5, 10'h1B0);
    cycle(); cycle(); cycle();
    rst = 1'b0;
    cycle();
    load(0, 1, 10'h0B0);
    cycle();
    rst = 1'b1;
    clear_log();
    run_idle("t1");
    if (log_vc.size() >= 1) check("t1_first_vc", 32'(log_vc[0]), 32'd0);
    else check("t1_first_vc_missing", 32'(log_vc.size()), 32'd1);

    // Randomized traffic with backpressure, enable gaps and rare resets.
    for (int n = 0; n < 600; n++) begin
      enb         = ($urandom_range(0, 9) != 0);
      almost_full = ($urandom_range(0, 3) == 0);
      rst         = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 2) == 0) begin
        int v;
        v = $urandom_range(0, 3);
        if (fifo_q[v].size() < 8) fifo_q[v].push_back(DW'($urandom));
      end
      cycle();
    end
    rst = 1'b1; enb = 1'b1; almost_full = 1'b0;
    run_idle("rand_drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
